// File: rtl/pwm_bank_pkg.sv
// Shared constants and helpers for the PWM bank: default parameters,
// channel slice indexing into the packed duty frame, and output polarity.
package pwm_bank_pkg;

  localparam int DEF_CHANNELS     = 10;
  localparam int DEF_DUTY_W       = 16;
  localparam int DEF_PRESCALE     = 1;
  localparam int DEF_WDOG_PERIODS = 50;
  localparam bit DEF_ACTIVE_HIGH  = 1'b1;

  // Channel 0 sits in the MSBs of the frame, so the LSB offset counts down.
  function automatic int chan_lsb(int ch, int channels, int duty_w);
    return (channels - ch - 1) * duty_w;
  endfunction

  // Maps a logical "active" bit onto the pin level for the chosen polarity.
  function automatic logic drive_level(logic act, bit active_high);
    return active_high ? act : ~act;
  endfunction

  // Register width able to hold values 0..n-1, never narrower than one bit.
  function automatic int min_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Frame load strobe, enable and status/output signals of the PWM bank.
interface pwm_bank_if #(
  parameter int CHANNELS = pwm_bank_pkg::DEF_CHANNELS,
  parameter int DUTY_W   = pwm_bank_pkg::DEF_DUTY_W
);

  logic                       load_valid;
  logic [CHANNELS*DUTY_W-1:0] load_data;
  logic                       enable;
  logic [CHANNELS-1:0]        pwm_out;
  logic                       period_start;
  logic                       pending;
  logic                       failsafe;

  modport master (
    output load_valid, load_data, enable,
    input  pwm_out, period_start, pending, failsafe
  );

  modport slave (
    input  load_valid, load_data, enable,
    output pwm_out, period_start, pending, failsafe
  );

endinterface

// File: rtl/pwm_bank_timebase.sv
// Shared prescaler and period counter. Both are held at zero while disabled
// so that re-enabling always starts a fresh period.
module pwm_bank_timebase
  import pwm_bank_pkg::*;
#(
  parameter int DUTY_W   = DEF_DUTY_W,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [DUTY_W-1:0] cnt,
  output logic              wrap,
  output logic              period_first
);

  localparam int PS_W = min_width(PRESCALE);

  logic [PS_W-1:0] prescaler;
  logic            tick;

  assign tick         = enable && (prescaler == PS_W'(PRESCALE - 1));
  assign wrap         = tick && (&cnt);
  assign period_first = enable && (prescaler == '0) && (cnt == '0);

  // Prescaler divides clk down to counts; cnt wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      cnt       <= '0;
    end else if (!enable) begin
      prescaler <= '0;
      cnt       <= '0;
    end else if (tick) begin
      prescaler <= '0;
      cnt       <= cnt + DUTY_W'(1);
    end else begin
      prescaler <= prescaler + PS_W'(1);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with double-buffered duty frames and a link-loss
// watchdog. Frames are committed to all channels together at a period wrap
// (or immediately while disabled) so a period is never split between duties.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int DUTY_W       = DEF_DUTY_W,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int WDOG_PERIODS = DEF_WDOG_PERIODS,
  parameter bit ACTIVE_HIGH  = DEF_ACTIVE_HIGH
) (
  input logic       clk,
  input logic       rst_n,
  pwm_bank_if.slave bus
);

  logic [DUTY_W-1:0]   cnt;
  logic                wrap;
  logic                period_first;
  logic                commit;
  logic                run;
  logic [CHANNELS-1:0] drive;

  pwm_bank_timebase #(
    .DUTY_W   (DUTY_W),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (bus.enable),
    .cnt          (cnt),
    .wrap         (wrap),
    .period_first (period_first)
  );

  // A load coinciding with commit still commits the old shadow contents;
  // the new frame simply stays pending for the following boundary.
  assign commit = bus.pending && (wrap || !bus.enable);
  assign run    = bus.enable && !bus.failsafe;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam int LSB = chan_lsb(i, CHANNELS, DUTY_W);

    logic [DUTY_W-1:0] shadow;
    logic [DUTY_W-1:0] active;

    // Shadow captures every frame; active only changes on commit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow <= '0;
        active <= '0;
      end else begin
        if (bus.load_valid) shadow <= bus.load_data[LSB +: DUTY_W];
        if (commit)         active <= shadow;
      end
    end

    assign drive[i] = drive_level((cnt < active) && run, ACTIVE_HIGH);
  end

  // Registered pins and period marker, both one clock behind cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pwm_out      <= {CHANNELS{drive_level(1'b0, ACTIVE_HIGH)}};
      bus.period_start <= 1'b0;
    end else begin
      bus.pwm_out      <= drive;
      bus.period_start <= period_first;
    end
  end

  // Pending tracks an uncommitted frame; a fresh load always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              bus.pending <= 1'b0;
    else if (bus.load_valid) bus.pending <= 1'b1;
    else if (commit)         bus.pending <= 1'b0;
  end

  if (WDOG_PERIODS > 0) begin : g_wdog
    localparam int WD_W = min_width(WDOG_PERIODS + 1);

    logic [WD_W-1:0] wd_cnt;

    // Counts wraps since the last frame; wrap never fires while disabled,
    // so the watchdog is naturally frozen then. Starts tripped after reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wd_cnt       <= '0;
        bus.failsafe <= 1'b1;
      end else if (bus.load_valid) begin
        wd_cnt       <= '0;
        bus.failsafe <= 1'b0;
      end else if (wrap && (wd_cnt != WD_W'(WDOG_PERIODS))) begin
        wd_cnt <= wd_cnt + WD_W'(1);
        if (wd_cnt == WD_W'(WDOG_PERIODS - 1)) bus.failsafe <= 1'b1;
      end
    end
  end else begin : g_no_wdog
    assign bus.failsafe = 1'b0;
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Testbench for pwm_bank: directed frame loads, a period-level behavioural
// model compared every cycle, and literal per-period high-time expectations.
module tb_pwm_bank;

  localparam int CH     = 3;
  localparam int DW     = 4;
  localparam int PS     = 2;
  localparam int WDOG   = 2;
  localparam int PERIOD = PS * (1 << DW);

  typedef struct packed {
    logic [31:0]           t;
    logic [CH-1:0][DW-1:0] active;
    logic [CH-1:0][DW-1:0] shadow;
    logic                  pending;
    logic                  fs;
    logic [1:0]            wraps;
    logic [CH-1:0]         out;
    logic                  ps;
  } model_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   started = 1'b0;
  model_t m;
  int     check_count = 0;
  int     pass_count = 0;

  pwm_bank_if #(.CHANNELS(CH), .DUTY_W(DW)) bus ();

  pwm_bank #(
    .CHANNELS     (CH),
    .DUTY_W       (DW),
    .PRESCALE     (PS),
    .WDOG_PERIODS (WDOG),
    .ACTIVE_HIGH  (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t r;
    r    = '0;
    r.fs = 1'b1;
    return r;
  endfunction

  // One clock of the ideal block: time since enable gives the count,
  // duties change only on a period boundary or while disabled.
  function automatic model_t model_step(model_t s, logic en, logic lv,
                                        logic [CH*DW-1:0] ld);
    model_t n;
    int     cnt;
    logic   wrap;
    n    = s;
    cnt  = (int'(s.t) / PS) % (1 << DW);
    wrap = en && ((int'(s.t) % PERIOD) == PERIOD - 1);
    for (int i = 0; i < CH; i++)
      n.out[i] = en && !s.fs && (cnt < int'(s.active[i]));
    n.ps = en && ((int'(s.t) % PERIOD) == 0);
    if (s.pending && (wrap || !en)) begin
      n.active  = s.shadow;
      n.pending = 1'b0;
    end
    if (lv) begin
      for (int i = 0; i < CH; i++) n.shadow[i] = ld[(CH-i)*DW-1 -: DW];
      n.pending = 1'b1;
      n.wraps   = 2'd0;
      n.fs      = 1'b0;
    end else if (wrap && (int'(s.wraps) < WDOG)) begin
      n.wraps = s.wraps + 2'd1;
      if (int'(n.wraps) == WDOG) n.fs = 1'b1;
    end
    n.t = en ? s.t + 32'd1 : 32'd0;
    return n;
  endfunction

  function automatic logic [CH*DW-1:0] frame(int c0, int c1, int c2);
    return {DW'(c0), DW'(c1), DW'(c2)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                  name, actual, expected, $time);
  endtask

  // Drives a one-cycle load strobe, returning at the next falling edge.
  task automatic applyStimulus(input logic [CH*DW-1:0] data);
    bus.load_data  = data;
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic waitPeriodStart();
    int n;
    n = 0;
    while (bus.period_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.period_start !== 1'b1) checkOutput("period_start_timeout", 0, 1);
  endtask

  // Counts high cycles per channel over one period starting at this edge.
  task automatic countPeriod(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (bus.pwm_out[0]) c0++;
      if (bus.pwm_out[1]) c1++;
      if (bus.pwm_out[2]) c2++;
      @(negedge clk);
    end
  endtask

  // Behavioural model advances on every clock and resets asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, bus.enable, bus.load_valid, bus.load_data);
  end

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("pwm_out", 32'(bus.pwm_out), 32'(m.out));
      checkOutput("period_start", 32'(bus.period_start), 32'(m.ps));
      checkOutput("pending", 32'(bus.pending), 32'(m.pending));
      checkOutput("failsafe", 32'(bus.failsafe), 32'(m.fs));
    end
  end

  initial begin
    int c0, c1, c2, ps_count;
    rst_n          = 1'b1;
    bus.enable     = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    #2 rst_n = 1'b0;
    started = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_pwm_out", 32'(bus.pwm_out), 0);
    checkOutput("reset_failsafe", 32'(bus.failsafe), 1);
    checkOutput("reset_pending", 32'(bus.pending), 0);
    rst_n = 1'b1;

    $display("[TB] no frame: outputs off, period_start every %0d clocks", PERIOD);
    waitPeriodStart();
    ps_count = 0;
    for (int k = 0; k < 2 * PERIOD; k++) begin
      if (bus.period_start) ps_count++;
      @(negedge clk);
    end
    checkOutput("ps_per_64_clocks", 32'(ps_count), 2);

    $display("[TB] first frame 0/8/15 mid-period");
    repeat (5) @(negedge clk);
    applyStimulus(frame(0, 8, 15));
    checkOutput("load_pending", 32'(bus.pending), 1);
    checkOutput("load_clears_failsafe", 32'(bus.failsafe), 0);
    waitPeriodStart();
    countPeriod(c0, c1, c2);
    checkOutput("duty0_high", 32'(c0), 0);
    checkOutput("duty8_high", 32'(c1), 16);
    checkOutput("duty15_high", 32'(c2), 30);
    checkOutput("wdog_trip_failsafe", 32'(bus.failsafe), 1);
    checkOutput("wdog_trip_pwm_out", 32'(bus.pwm_out), 0);

    $display("[TB] two loads in one period, last wins");
    repeat (4) @(negedge clk);
    applyStimulus(frame(0, 4, 15));
    repeat (3) @(negedge clk);
    applyStimulus(frame(0, 12, 15));
    waitPeriodStart();
    countPeriod(c0, c1, c2);
    checkOutput("last_frame_wins", 32'(c1), 24);

    $display("[TB] load on the wrap cycle");
    waitPeriodStart();
    repeat (5) @(negedge clk);
    applyStimulus(frame(0, 8, 15));
    repeat (24) @(negedge clk);
    applyStimulus(frame(0, 2, 15));
    checkOutput("wrap_load_pending", 32'(bus.pending), 1);
    @(negedge clk);
    countPeriod(c0, c1, c2);
    checkOutput("wrap_load_old_shadow", 32'(c1), 16);
    countPeriod(c0, c1, c2);
    checkOutput("wrap_load_new_frame", 32'(c1), 4);
    checkOutput("wdog_again_failsafe", 32'(bus.failsafe), 1);
    checkOutput("wdog_again_pwm_out", 32'(bus.pwm_out), 0);

    $display("[TB] recovery from failsafe");
    applyStimulus(frame(0, 8, 15));
    checkOutput("recover_failsafe", 32'(bus.failsafe), 0);
    waitPeriodStart();
    countPeriod(c0, c1, c2);
    checkOutput("recover_duty8", 32'(c1), 16);
    checkOutput("recover_duty15", 32'(c2), 30);

    $display("[TB] disabled load and restart");
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    applyStimulus(frame(5, 0, 0));
    checkOutput("disabled_pending_set", 32'(bus.pending), 1);
    @(negedge clk);
    checkOutput("disabled_pending_clear", 32'(bus.pending), 0);
    checkOutput("disabled_pwm_out", 32'(bus.pwm_out), 0);
    bus.enable = 1'b1;
    waitPeriodStart();
    countPeriod(c0, c1, c2);
    checkOutput("restart_duty5", 32'(c0), 10);

    $display("[TB] asynchronous reset mid-period");
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_pwm_out", 32'(bus.pwm_out), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_pwm_out", 32'(bus.pwm_out), 0);
    checkOutput("async_reset_pending", 32'(bus.pending), 0);
    checkOutput("async_reset_failsafe", 32'(bus.failsafe), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator driven by a shared timebase, loaded with a full frame of duty values from the SPI receive path. Duty values are double-buffered: a frame lands in shadow registers and is committed to all channels together at the next period boundary, so outputs never glitch mid-period. A link-loss watchdog forces every output inactive when frames stop arriving. It sits between the clk-domain SPI frame strobe and the PWM output pins.

## Interface
- CHANNELS, 10, number of PWM outputs
- DUTY_W, 16, duty and counter width in bits; period is 2^DUTY_W counts
- PRESCALE, 1, clk cycles per count (≥1)
- WDOG_PERIODS, 50, number of periods without a load before failsafe trips; 0 disables the watchdog
- ACTIVE_HIGH, 1, output polarity: 1 means active = 1

- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous, active-low reset
- load_valid  in  1  one-cycle strobe: load_data is valid this cycle; already synchronised to clk upstream
- load_data  in  CHANNELS*DUTY_W  duty frame; channel i = load_data[(CHANNELS-i)*DUTY_W-1 -: DUTY_W], so channel 0 occupies the MSBs
- enable  in  1  0 forces all outputs inactive and holds the timebase
- pwm_out  out  CHANNELS  registered PWM outputs
- period_start  out  1  one-cycle pulse aligned with the first output cycle of each period
- pending  out  1  shadow holds an uncommitted frame
- failsafe  out  1  watchdog tripped; outputs forced inactive

## Operation
- Timebase: the prescaler counts 0..PRESCALE-1. tick = (prescaler == PRESCALE-1). cnt advances on each tick and wraps from 2^DUTY_W-1 to 0. wrap = tick && cnt == all-ones.
- Load: load_valid writes shadow[] and sets pending. A second load before commit overwrites shadow (last frame wins).
- Commit: on wrap with pending set, active[] <= shadow[] and pending clears.
  - If load_valid coincides with wrap, the commit uses the old shadow. The new frame is stored and stays pending for the next wrap.
- Compare: raw_i = (cnt < active_i). duty 0 means never active. duty 2^DUTY_W-1 means active for all but one count.
- Output: pwm_out_i = active level if (raw_i && enable && !failsafe), else inactive level (XOR with !ACTIVE_HIGH).
- enable = 0:
  - prescaler and cnt are held at 0 and outputs are inactive.
  - Loads are still accepted and commit immediately, the cycle after load_valid.
  - The watchdog is frozen.
  - When enable rises, counting starts from cnt = 0 with the committed duties.
- Watchdog:
  - Counts wraps since the last load_valid. load_valid clears the count and clears failsafe.
  - When the count reaches WDOG_PERIODS, failsafe sets and the count saturates.
  - failsafe does not alter active[]. The next frame commits normally at the next wrap.
- Reset values:
  - cnt = 0, prescaler = 0, shadow = 0, active = 0, pending = 0, period_start = 0.
  - pwm_out = inactive level for all channels.
  - failsafe = 1 when WDOG_PERIODS > 0, so outputs stay off until the first frame; 0 otherwise.
- Reset asserted mid-period returns all state to reset values asynchronously. No partial frame survives.

## Timing
- pwm_out and period_start are registered: output at clock k+1 reflects cnt and active at clock k.
- Load-to-output latency:
  - Enabled: at most PRESCALE*2^DUTY_W + 1 clocks (next wrap, plus the output register).
  - Disabled: 2 clocks.
- period_start pulses in the same cycle that pwm_out first shows cnt = 0.
- Changes to failsafe and enable take effect on pwm_out one clock later.
- Period = PRESCALE*2^DUTY_W clocks. Defaults give 65536 clocks, about 763 Hz at 50 MHz.

## Structure
- Shared package/header holds:
  - default parameter constants;
  - the channel-slice index macro/function;
  - the polarity helper.
- Sub-module pwm_bank_timebase holds the prescaler, cnt, tick and wrap, and has an enable hold. The top level holds per-channel shadow/active/compare (generate loop) and the watchdog.
- No SPI logic in this block; the frame strobe arrives already in the clk domain.

## Test plan
Bench parameters: CHANNELS=3, DUTY_W=4, PRESCALE=2, WDOG_PERIODS=2, ACTIVE_HIGH=1.

- Reset release, enable=1, no load -> pwm_out=000 and failsafe=1 indefinitely; period_start pulses every 32 clocks.
- load_data=0x0_8_F (ch0=0, ch1=8, ch2=15) mid-period -> pending=1 until the wrap; then per 32-clock period ch0 stays 0, ch1 is high for 16 clocks, ch2 is high for 30 clocks; failsafe clears on the load.
- Two loads in one period (ch1=4, then ch1=12) -> only 12 commits; no 4-count period is observed.
- load_valid on the exact wrap cycle with ch1=2 while the old shadow holds 8 -> the next period uses 8, the following period uses 2.
- No loads for 2 wraps after a valid frame -> failsafe=1 and all outputs go low 1 clock later; a new load clears failsafe, and its duties appear after the next wrap.
- enable=0 mid-period, load ch0=5 -> outputs stay low, pending clears after 1 clock; enable=1 -> cnt restarts at 0 and ch0 is high for 10 clocks. Separately, rst_n pulsed mid-period -> all outputs low immediately.
